// File: rtl/fp_add_arbiter_pkg.sv
// Shared definitions for the fp_add sharing slice: rounding-mode codes,
// FP32 special encodings, flag bit positions, adder latency and the
// round-increment helper used by the adder's rounding stage.
package fp_add_arbiter_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RZ  = 3'd1,
    RM_RD  = 3'd2,
    RM_RU  = 3'd3,
    RM_RNA = 3'd4
  } rm_e;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [30:0] FP_MAX_MAG  = 31'h7F7F_FFFF;

  localparam int unsigned FLG_OV  = 3;
  localparam int unsigned FLG_UN  = 2;
  localparam int unsigned FLG_INV = 1;
  localparam int unsigned FLG_INX = 0;
  localparam int unsigned FP_LAT  = 2;

  // Whether the kept mantissa must be incremented, given the result sign,
  // its lsb, the guard bit and the OR of everything below the guard.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic sign,
                                   input logic lsb, input logic g, input logic st);
    logic inc;
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (st | lsb);
      RM_RNA:  inc = g;
      RM_RU:   inc = (g | st) & ~sign;
      RM_RD:   inc = (g | st) & sign;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_add.sv
// Two-stage pipelined FP32 adder, one issue per cycle, no back-pressure.
// Operands applied in cycle C produce out/flags registered for cycle C+2.
// Ports: clk, rst_n (async, active-low), a, b, rm -> out, ov, un, inv, inexact.
module fp_add
  import fp_add_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rm,
  output logic [31:0] out,
  output logic        ov,
  output logic        un,
  output logic        inv,
  output logic        inexact
);

  // ---- stage 1: specials, swap, align, add ----
  logic        a_nan, b_nan, a_inf, b_inf, a_big, eff_add;
  logic [31:0] l_op, s_op;
  logic [7:0]  l_exp, s_exp, d;
  logic [23:0] l_man, s_man;
  logic [26:0] s_wide, s_al, mask;
  logic [27:0] sum;
  logic        spec, spec_inv;
  logic [31:0] spec_val;

  always_comb begin
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_big   = a[30:0] >= b[30:0];
    l_op    = a_big ? a : b;
    s_op    = a_big ? b : a;
    eff_add = ~(a[31] ^ b[31]);
    // Subnormals use exponent 1 with a zero hidden bit.
    l_exp   = (l_op[30:23] == '0) ? 8'd1 : l_op[30:23];
    s_exp   = (s_op[30:23] == '0) ? 8'd1 : s_op[30:23];
    l_man   = {l_op[30:23] != '0, l_op[22:0]};
    s_man   = {s_op[30:23] != '0, s_op[22:0]};
    d       = l_exp - s_exp;
    s_wide  = {s_man, 3'b000};
    mask    = ~({27{1'b1}} << d);
    if (d >= 8'd27) begin
      s_al = {26'b0, |s_man};
    end else begin
      s_al    = s_wide >> d;
      s_al[0] = s_al[0] | (|(s_wide & mask));
    end
    sum = eff_add ? ({1'b0, l_man, 3'b000} + {1'b0, s_al})
                  : ({1'b0, l_man, 3'b000} - {1'b0, s_al});

    spec     = 1'b0;
    spec_inv = 1'b0;
    spec_val = FP_POS_ZERO;
    if (a_nan || b_nan) begin
      spec     = 1'b1;
      spec_val = FP_QNAN;
      spec_inv = (a_nan & ~a[22]) | (b_nan & ~b[22]);
    end else if (a_inf && b_inf && (a[31] != b[31])) begin
      spec     = 1'b1;
      spec_val = FP_QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec     = 1'b1;
      spec_val = a;
    end else if (b_inf) begin
      spec     = 1'b1;
      spec_val = b;
    end
  end

  logic        s1_spec, s1_spec_inv, s1_sign, s1_add;
  logic [31:0] s1_spec_val;
  logic [7:0]  s1_exp;
  logic [27:0] s1_sum;
  logic [2:0]  s1_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_spec <= 1'b0; s1_spec_inv <= 1'b0; s1_spec_val <= '0;
      s1_sign <= 1'b0; s1_add <= 1'b0; s1_exp <= '0; s1_sum <= '0;
      s1_rm   <= RM_RNE;
    end else begin
      s1_spec <= spec; s1_spec_inv <= spec_inv; s1_spec_val <= spec_val;
      s1_sign <= l_op[31]; s1_add <= eff_add; s1_exp <= l_exp; s1_sum <= sum;
      s1_rm   <= rm;
    end
  end

  // ---- stage 2: normalise, round, pack ----
  logic [4:0]  lz;
  logic [9:0]  exp10, sh, e, ef;
  logic [26:0] norm;
  logic [24:0] m25;
  logic        inc, inx, zsign;
  logic [31:0] res;
  logic        r_ov, r_un, r_inv, r_inx;

  always_comb begin
    exp10 = {2'b00, s1_exp};
    lz    = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (s1_sum[i]) lz = 5'(26 - i);
    sh    = '0;
    norm  = s1_sum[26:0];
    e     = exp10;
    if (s1_sum[27]) begin
      norm = {s1_sum[27:2], s1_sum[1] | s1_sum[0]};
      e    = exp10 + 10'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results become subnormal.
      sh   = ({5'b0, lz} < exp10) ? {5'b0, lz} : exp10 - 10'd1;
      norm = s1_sum[26:0] << sh;
      e    = exp10 - sh;
    end
    inx   = norm[2] | (|norm[1:0]);
    inc   = rnd_inc(s1_rm, s1_sign, norm[3], norm[2], |norm[1:0]);
    m25   = {1'b0, norm[26:3]} + {24'b0, inc};
    ef    = m25[24] ? e + 10'd1 : (m25[23] ? e : 10'd0);
    zsign = s1_add ? s1_sign : (s1_rm == RM_RD);

    r_ov  = 1'b0;
    r_un  = 1'b0;
    r_inv = 1'b0;
    r_inx = 1'b0;
    if (s1_spec) begin
      res   = s1_spec_val;
      r_inv = s1_spec_inv;
    end else if (s1_sum == '0) begin
      res = {zsign, 31'b0};
    end else if (ef >= 10'd255) begin
      r_ov  = 1'b1;
      r_inx = 1'b1;
      if ((s1_rm == RM_RZ) || (s1_rm == RM_RU && s1_sign) || (s1_rm == RM_RD && !s1_sign))
        res = {s1_sign, FP_MAX_MAG};
      else
        res = {s1_sign, FP_POS_INF[30:0]};
    end else begin
      res   = {s1_sign, ef[7:0], m25[24] ? m25[23:1] : m25[22:0]};
      r_inx = inx;
      r_un  = inx & ~m25[24] & ~m25[23];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0; ov <= 1'b0; un <= 1'b0; inv <= 1'b0; inexact <= 1'b0;
    end else begin
      out <= res; ov <= r_ov; un <= r_un; inv <= r_inv; inexact <= r_inx;
    end
  end

endmodule

// File: rtl/fp_add_arbiter_rr.sv
// Round-robin arbiter: first eligible requester at or after ptr wins,
// wrapping NREQ-1 -> 0. Grant is combinational; ptr advances past the
// winner on every grant. Ports: clk, rst, req, hold -> grant (one-hot/zero),
// win_id (valid when |grant).
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            hold,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win_id
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] elig;
  logic [IDW:0]    pos;
  logic            found;

  always_comb begin
    elig   = hold ? '0 : req;
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + (IDW + 1)'(i);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!found && elig[pos[IDW-1:0]]) begin
        found                = 1'b1;
        grant[pos[IDW-1:0]]  = 1'b1;
        win_id               = pos[IDW-1:0];
      end
    end
    // No handshake may complete while reset is asserted.
    if (rst) begin
      grant = '0;
      found = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined fp_add among NREQ requesters. Round-robin grant,
// registered issue into the adder, a {valid,id} tag pipe of depth 1+LAT that
// tracks each op, and one-hot response routing back to the issuer.
// Ports: clk, rst; req_valid/req_ready/req_a/req_b/req_rm per requester;
// hold blocks new grants; rsp_valid/rsp_id/rsp_data/rsp_flags; busy.
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = FP_LAT,
  parameter int unsigned W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_rm,
  input  logic              hold,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    mux_a, mux_b, iss_a, iss_b, add_out;
  logic [2:0]      mux_rm, iss_rm;
  logic            add_ov, add_un, add_inv, add_inx;
  logic [LAT:0]    tag_v;
  logic [IDW-1:0]  tag_id [LAT+1];

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .hold   (hold),
    .grant  (grant),
    .win_id (win_id)
  );

  assign req_ready = grant;

  // Idle cycles feed +0 + +0 in RNe so the adder never sees stale operands.
  always_comb begin
    mux_a  = FP_POS_ZERO;
    mux_b  = FP_POS_ZERO;
    mux_rm = RM_RNE;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        mux_a  = req_a[k*W +: W];
        mux_b  = req_b[k*W +: W];
        mux_rm = req_rm[k*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_a  <= '0;
      iss_b  <= '0;
      iss_rm <= RM_RNE;
      tag_v  <= '0;
      for (int unsigned i = 0; i <= LAT; i++) tag_id[i] <= '0;
    end else begin
      iss_a     <= mux_a;
      iss_b     <= mux_b;
      iss_rm    <= mux_rm;
      tag_v     <= {tag_v[LAT-1:0], |grant};
      tag_id[0] <= win_id;
      for (int unsigned i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  fp_add u_add (
    .clk     (clk),
    .rst_n   (~rst),
    .a       (iss_a),
    .b       (iss_b),
    .rm      (iss_rm),
    .out     (add_out),
    .ov      (add_ov),
    .un      (add_un),
    .inv     (add_inv),
    .inexact (add_inx)
  );

  // Tag tail and adder output registers line up: both describe the op
  // whose handshake was LAT+1 cycles ago.
  always_comb begin
    rsp_valid = '0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_flags = '0;
    if (tag_v[LAT]) begin
      rsp_valid = NREQ'(1) << tag_id[LAT];
      rsp_id    = tag_id[LAT];
      rsp_data  = add_out;
      rsp_flags = {add_ov, add_un, add_inv, add_inx};
    end
  end

  assign busy = |tag_v;

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;
  import fp_add_arbiter_pkg::*;

  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] FOUR  = 32'h4080_0000;

  logic         clk, rst, hold, busy;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_flags;
  logic [127:0] req_a, req_b;
  logic [11:0]  req_rm;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;

  int n_chk  = 0;
  int n_pass = 0;

  fp_add_arbiter #(.NREQ(4), .IDW(2), .LAT(2), .W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rm    (req_rm),
    .hold      (hold),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned k, input logic [31:0] a, input logic [31:0] b);
    req_valid[k]        = 1'b1;
    req_a[k*32 +: 32]   = a;
    req_b[k*32 +: 32]   = b;
    req_rm[k*3 +: 3]    = RM_RNE;
  endtask

  // One op from requester k issued alone; response expected 3 cycles later.
  task automatic single_op(input string nm, input int unsigned k, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_d,
                           input logic [3:0] exp_f);
    set_op(k, a, b);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk({nm, "_ready"}, 32'(req_ready), (t == 0) ? (32'd1 << k) : 32'd0);
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), (t == 3) ? (32'd1 << k) : 32'd0);
      if (t == 3) begin
        chk({nm, "_rsp_id"}, 32'(rsp_id), k);
        chk({nm, "_rsp_data"}, rsp_data, exp_d);
        chk({nm, "_rsp_flags"}, 32'(rsp_flags), 32'(exp_f));
      end
      next_cycle();
      if (t == 0) req_valid[k] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] exp_d [3];
    exp_d[0] = TWO; exp_d[1] = FOUR; exp_d[2] = THREE;

    rst = 1'b1; hold = 1'b0; req_valid = 4'b1111;
    req_a = '0; req_b = '0; req_rm = '0;

    // Reset state, with requests present to confirm no grant under reset.
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    next_cycle();
    rst = 1'b0;

    // All four valid from ptr=0: fixed rotation, responses in same order.
    for (int unsigned k = 0; k < 4; k++) set_op(k, ONE, ONE);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("rot_ready", 32'(req_ready), (t < 4) ? (32'd1 << t) : 32'd0);
      chk("rot_rsp_valid", 32'(rsp_valid), (t >= 3 && t < 7) ? (32'd1 << (t - 3)) : 32'd0);
      if (t >= 3 && t < 7) begin
        chk("rot_rsp_id", 32'(rsp_id), 32'(t - 3));
        chk("rot_rsp_data", rsp_data, TWO);
      end
      next_cycle();
      if (t < 4) req_valid[t] = 1'b0;
    end

    single_op("one_plus_two", 0, ONE, TWO, THREE, 4'b0000);
    single_op("inf_minus_inf", 2, 32'h7F80_0000, 32'hFF80_0000, FP_QNAN, 4'b0010);

    // Hold with an op in flight: response still arrives, req3 waits for hold.
    set_op(1, ONE, ONE);
    @(negedge clk);
    chk("hold_ready_r1", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid[1] = 1'b0;
    hold = 1'b1;
    set_op(3, TWO, TWO);
    for (int t = 1; t < 8; t++) begin
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), (t == 4) ? 32'b1000 : 32'd0);
      chk("hold_rsp_valid", 32'(rsp_valid), (t == 3) ? 32'b0010 : (t == 7) ? 32'b1000 : 32'd0);
      if (t == 3) chk("hold_rsp_data_r1", rsp_data, TWO);
      if (t == 7) begin
        chk("hold_rsp_id_r3", 32'(rsp_id), 32'd3);
        chk("hold_rsp_data_r3", rsp_data, FOUR);
      end
      next_cycle();
      if (t == 3) hold = 1'b0;
      if (t == 4) req_valid[3] = 1'b0;
    end

    // Back-to-back ops from one requester: in-order results and busy window.
    set_op(0, ONE, ONE);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(req_ready), (t < 3) ? 32'b0001 : 32'd0);
      chk("b2b_busy", 32'(busy), (t >= 1 && t <= 5) ? 32'd1 : 32'd0);
      chk("b2b_rsp_valid", 32'(rsp_valid), (t >= 3 && t <= 5) ? 32'b0001 : 32'd0);
      if (t >= 3 && t <= 5) chk("b2b_rsp_data", rsp_data, exp_d[t-3]);
      next_cycle();
      if (t == 0) set_op(0, TWO, TWO);
      if (t == 1) set_op(0, ONE, TWO);
      if (t == 2) req_valid[0] = 1'b0;
    end

    // Reset one cycle after issue drops the op and returns ptr to 0.
    set_op(1, ONE, ONE);
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'b0010);
    next_cycle();
    rst = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_mid_ready_in_rst", 32'(req_ready), 32'd0);
    chk("rst_mid_busy_in_rst", 32'(busy), 32'd0);
    chk("rst_mid_rsp_in_rst", 32'(rsp_valid), 32'd0);
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
    for (int t = 2; t < 5; t++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      next_cycle();
    end
    for (int unsigned k = 0; k < 4; k++) set_op(k, ONE, ONE);
    @(negedge clk);
    chk("rst_mid_ptr0", 32'(req_ready), 32'b0001);
    next_cycle();
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
